// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl: sequencer that shifts a parallel word out MSB-first and captures a serial word back in.
// Ports:
//   clk_i        rising-edge clock
//   clr_ni       asynchronous active-low clear
//   tx_data_i    parallel word to transmit, taken when tx_valid_i && tx_ready_o
//   tx_valid_i   tx_data_i valid
//   tx_ready_o   high in IDLE, controller can accept a word
//   abort_i      synchronous abort of the current transfer, wins over tick and rx_ready_i
//   sin_i        serial input, sampled on the edge that ends each bit window
//   sout_o       serial output, MSB first, 0 outside SHIFT
//   shift_tick_o one-cycle strobe marking the last cycle of each bit window
//   rx_data_o    captured word, stable while rx_valid_o is high
//   rx_valid_o   rx_data_o valid (DONE state)
//   rx_ready_i   consumer accepts rx_data_o
//   busy_o       controller is not IDLE
module shift_chain_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic             abort_i,
    input  logic             sin_i,
    output logic             sout_o,
    output logic             shift_tick_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             busy_o
);
    localparam int BW = $clog2(WIDTH);
    localparam int DW = $clog2(DIV + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, rx_data_q, rx_data_d, shifted;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             tick, last;
    logic             tx_ready_q, rx_valid_q, busy_q, sout_q, shift_tick_q;

    assign tick    = state_q == SHIFT && div_cnt_q == DW'(DIV - 1);
    assign last    = bit_cnt_q == BW'(WIDTH - 1);
    assign shifted = {shreg_q[WIDTH-2:0], sin_i};

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        if (abort_i && state_q != IDLE) begin
            state_d   = IDLE;
            shreg_d   = '0;
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: if (tx_valid_i && !abort_i) begin
                    state_d   = SHIFT;
                    shreg_d   = tx_data_i;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
                SHIFT: if (tick) begin
                    shreg_d   = shifted;
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last) begin
                        rx_data_d = shifted;
                        state_d   = DONE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
                DONE: if (rx_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            tx_ready_q   <= 1'b1;
            rx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            sout_q       <= 1'b0;
            shift_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            tx_ready_q   <= state_d == IDLE;
            rx_valid_q   <= state_d == DONE;
            busy_q       <= state_d != IDLE;
            sout_q       <= state_d == SHIFT && shreg_d[WIDTH-1];
            shift_tick_q <= state_d == SHIFT && div_cnt_d == DW'(DIV - 1);
        end
    end

    assign tx_ready_o   = tx_ready_q;
    assign rx_valid_o   = rx_valid_q;
    assign busy_o       = busy_q;
    assign sout_o       = sout_q;
    assign shift_tick_o = shift_tick_q;
    assign rx_data_o    = rx_data_q;
endmodule

// File: doc/shift_chain_ctrl.md
# shift_chain_ctrl

Sequencing controller for a WIDTH-bit serial shift chain of clear-able D flip-flops. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per DIV clocks. It captures the same number of serial-input bits into a parallel receive word and presents that word over a second valid/ready handshake. It sits between a parallel producer/consumer and the serial link built from the team's shift-register flip-flop stages.

## Interface
- WIDTH, 4, bits per transfer (≥2)
- DIV, 1, clocks per bit (≥1); internal divider counter is $clog2(DIV+1) bits wide

- clk  in  1  single clock; all state changes on rising edge
- clr  in  1  asynchronous, active-low reset (clr=0 resets immediately, release synchronous to clk)
- tx_data  in  WIDTH  parallel word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  controller can accept a word
- abort  in  1  synchronous abort of current transfer
- sin  in  1  serial input bit
- sout  out  1  serial output bit (MSB first)
- shift_tick  out  1  one-cycle strobe on each bit-sample edge
- rx_data  out  WIDTH  captured word, held stable while rx_valid=1
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  consumer accepts rx_data
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (clr=0): state=IDLE, shreg=0, rx_data=0, bit_cnt=0, div_cnt=0. Outputs: tx_ready=1, rx_valid=0, sout=0, shift_tick=0, busy=0.
- IDLE:
  - tx_ready=1.
  - On tx_valid=1 and abort=0: shreg←tx_data, bit_cnt←0, div_cnt←0, go to SHIFT.
  - abort=1 in IDLE blocks acceptance and has no other effect.
- SHIFT:
  - sout=shreg[WIDTH-1].
  - div_cnt counts 0..DIV-1. shift_tick=1 when div_cnt==DIV-1.
  - On tick: shreg←{shreg[WIDTH-2:0], sin}, div_cnt←0, bit_cnt←bit_cnt+1.
  - On the tick with bit_cnt==WIDTH-1: rx_data←{shreg[WIDTH-2:0], sin}, go to DONE.
- DONE:
  - rx_valid=1, sout=0.
  - On rx_ready=1: go to IDLE.
  - tx_ready=0, so a tx_valid in the same cycle is not accepted. It is accepted in the following IDLE cycle.
- abort=1 in SHIFT or DONE: next state IDLE, shreg←0, counters←0, rx_valid deasserts next cycle, rx_data retains its old value. abort takes priority over tick and rx_ready.
- sout=0 and shift_tick=0 outside SHIFT.

## Timing
- Word accepted at edge k. SHIFT occupies cycles k+1 .. k+WIDTH·DIV.
- Bit i (MSB=bit 0) drives sout during cycles k+1+i·DIV .. k+(i+1)·DIV.
- sin is sampled at the rising edge ending each bit window, i.e. the edge while shift_tick=1.
- rx_valid first high in cycle k+1+WIDTH·DIV. It stays high until the edge where rx_ready=1.
- Minimum word-to-word period is WIDTH·DIV+2 cycles (rx_ready tied high): SHIFT, 1 DONE cycle, 1 IDLE cycle.
- Reset mid-transfer: all state clears asynchronously and no partial rx_valid is issued.

## Test plan
- WIDTH=4, DIV=1, tx_data=4'b1011, sin=0,1,1,0 on successive ticks, rx_ready=1 → sout=1,0,1,1 in cycles k+1..k+4; shift_tick high in k+1..k+4; rx_data=4'b0110 with rx_valid=1 in cycle k+5; IDLE in k+6.
- WIDTH=4, DIV=3, tx_data=4'hA, sin held 1 → each sout bit held 3 cycles (1,0,1,0); shift_tick every 3rd cycle; rx_data=4'hF; rx_valid in cycle k+13.
- Backpressure: complete a transfer with rx_ready=0 for 5 cycles and tx_valid=1 throughout → rx_valid and rx_data stable, tx_ready=0, busy=1. Raise rx_ready → IDLE next cycle; the next word is accepted one cycle later.
- Abort: DIV=1, assert abort after 2 ticks → IDLE next cycle; no rx_valid; rx_data unchanged; sout=0. abort in IDLE with tx_valid=1 → not accepted.
- Async reset: drop clr mid-SHIFT off a clock edge → state, sout, rx_valid and busy clear immediately. After release, tx_ready=1 and a new transfer completes correctly.
- Back-to-back: 3 words 4'h1, 4'h8, 4'hF with tx_valid and rx_ready held high → each accepted exactly WIDTH·DIV+2 cycles apart; sout streams match MSB-first order.
